// File: rtl/glyph_sched_pkg.sv
// rtl/glyph_sched_pkg.sv - shared types, field layout and helpers for glyph_scheduler
//
// Contents:
//   wdata field offsets/widths, slot_t record, scan FSM state type,
//   default glyph edge sizes, saturating end-coordinate and wdata unpack helpers.
package glyph_sched_pkg;

    localparam int WDATA_W  = 52;
    localparam int EN_BIT   = 51;
    localparam int MAIN_BIT = 50;
    localparam int CHAR_LSB = 44;
    localparam int CHAR_W   = 6;
    localparam int X_LSB    = 34;
    localparam int Y_LSB    = 24;
    localparam int COORD_W  = 10;
    localparam int COLOR_W  = 24;

    localparam int SMALL_SZ = 8;
    localparam int BIG_SZ   = 64;

    typedef struct packed {
        logic               en;
        logic               main;
        logic [CHAR_W-1:0]  chr;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COLOR_W-1:0] color;
    } slot_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_t;

    // Window end = start + size, clamped to the last addressable coordinate
    // so glyphs near the right/bottom edge are clipped rather than wrapped.
    function automatic logic [COORD_W-1:0] sat_end(input logic [COORD_W-1:0] start,
                                                   input logic [COORD_W:0]   sz);
        logic [COORD_W:0] sum;
        sum = {1'b0, start} + sz;
        return sum[COORD_W] ? {COORD_W{1'b1}} : sum[COORD_W-1:0];
    endfunction

    function automatic slot_t unpack_slot(input logic [WDATA_W-1:0] w);
        slot_t s;
        s.en    = w[EN_BIT];
        s.main  = w[MAIN_BIT];
        s.chr   = w[CHAR_LSB +: CHAR_W];
        s.x     = w[X_LSB +: COORD_W];
        s.y     = w[Y_LSB +: COORD_W];
        s.color = w[0 +: COLOR_W];
        return s;
    endfunction

endpackage

// File: rtl/glyph_prio_enc.sv
// rtl/glyph_prio_enc.sv - combinational lowest-index-wins priority encoder
//
// Ports:
//   req   in  N   request vector, bit 0 has highest priority
//   sel   out IW  index of the lowest set request bit (0 when none)
//   valid out 1   at least one request bit set
module glyph_prio_enc #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] sel,
    output logic          valid
);

    // Walk from the top down so the lowest index is the last to assign.
    always_comb begin
        sel   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel   = IW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/glyph_scheduler.sv
// rtl/glyph_scheduler.sv - per-line slot scan and per-pixel glyph selection
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   we, waddr, wdata           shadow-table write port
//   frame_start                commit shadow table to active table
//   line_start, next_line      start a scan of the active table for next_line
//   hcount, vcount             current pixel
//   rom_addr                   {main, char} to font ROM (stage 1)
//   main, x_start, x_end,      selected glyph window and colour (stage 2,
//   y_start, y_end, rgb_color  aligned with ROM data)
//   hit                        a slot covers the pixel (stage 2)
//   busy                       slot scan in progress
module glyph_scheduler #(
    parameter int N_SLOTS  = 8,
    parameter int SMALL_SZ = glyph_sched_pkg::SMALL_SZ,
    parameter int BIG_SZ   = glyph_sched_pkg::BIG_SZ,
    parameter int IW       = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               we,
    input  logic [IW-1:0]                      waddr,
    input  logic [glyph_sched_pkg::WDATA_W-1:0] wdata,
    input  logic                               frame_start,
    input  logic                               line_start,
    input  logic [9:0]                         next_line,
    input  logic [9:0]                         hcount,
    input  logic [9:0]                         vcount,
    output logic [6:0]                         rom_addr,
    output logic                               main,
    output logic [9:0]                         x_start,
    output logic [9:0]                         x_end,
    output logic [9:0]                         y_start,
    output logic [9:0]                         y_end,
    output logic [23:0]                        rgb_color,
    output logic                               hit,
    output logic                               busy
);

    import glyph_sched_pkg::*;

    localparam logic [COORD_W:0] SMALL_W = (COORD_W + 1)'(SMALL_SZ);
    localparam logic [COORD_W:0] BIG_W   = (COORD_W + 1)'(BIG_SZ);

    function automatic logic [COORD_W-1:0] end_of(input logic [COORD_W-1:0] start,
                                                  input logic               is_main);
        return sat_end(start, is_main ? BIG_W : SMALL_W);
    endfunction

    // ---------------- slot tables ----------------
    slot_t shadow_q [N_SLOTS];
    slot_t active_q [N_SLOTS];

    // Commit reads the pre-write shadow, so a same-cycle write waits a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            if (frame_start) begin
                for (int i = 0; i < N_SLOTS; i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
            if (we) begin
                shadow_q[waddr] <= unpack_slot(wdata);
            end
        end
    end

    // ---------------- line scan FSM ----------------
    scan_state_t          state_q, state_d;
    logic [IW-1:0]        idx_q;
    logic [9:0]           line_q;
    logic [N_SLOTS-1:0]   mask_work_q, mask_next, line_mask_q;
    logic                 scan_bit;
    logic                 last_idx;
    slot_t                scan_slot;

    assign last_idx  = (idx_q == IW'(N_SLOTS - 1));
    assign scan_slot = active_q[idx_q];
    assign scan_bit  = scan_slot.en && (scan_slot.y <= line_q) &&
                       (line_q < end_of(scan_slot.y, scan_slot.main));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (line_start) state_d = ST_SCAN;
            ST_SCAN: begin
                if (line_start)    state_d = ST_SCAN;
                else if (last_idx) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_SCAN);
    end

    // Working mask including the slot evaluated this cycle; published
    // to line_mask only once the final slot has been checked.
    always_comb begin
        mask_next        = mask_work_q;
        mask_next[idx_q] = scan_bit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q       <= '0;
            line_q      <= '0;
            mask_work_q <= '0;
            line_mask_q <= '0;
        end else if (line_start) begin
            idx_q       <= '0;
            line_q      <= next_line;
            mask_work_q <= '0;
        end else if (state_q == ST_SCAN) begin
            idx_q       <= idx_q + IW'(1);
            mask_work_q <= mask_next;
            if (last_idx) begin
                line_mask_q <= mask_next;
            end
        end
    end

    // ---------------- per-pixel selection ----------------
    logic [N_SLOTS-1:0] covers;
    logic [IW-1:0]      sel_idx;
    logic               sel_valid;
    slot_t              sel_slot;

    // vcount is re-checked because the mask may be from a different line.
    always_comb begin
        covers = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            covers[i] = line_mask_q[i] &&
                        (active_q[i].x <= hcount) &&
                        (hcount < end_of(active_q[i].x, active_q[i].main)) &&
                        (active_q[i].y <= vcount) &&
                        (vcount < end_of(active_q[i].y, active_q[i].main));
        end
    end

    glyph_prio_enc #(
        .N  (N_SLOTS),
        .IW (IW)
    ) u_prio (
        .req   (covers),
        .sel   (sel_idx),
        .valid (sel_valid)
    );

    assign sel_slot = active_q[sel_idx];

    logic               hit_s1, main_s1;
    logic [9:0]         xs_s1, xe_s1, ys_s1, ye_s1;
    logic [23:0]        color_s1;

    // Stage 1: ROM address issued here so ROM data lands with stage 2.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_s1   <= 1'b0;
            main_s1  <= 1'b0;
            xs_s1    <= '0;
            xe_s1    <= '0;
            ys_s1    <= '0;
            ye_s1    <= '0;
            color_s1 <= '0;
            rom_addr <= '0;
        end else begin
            hit_s1 <= sel_valid;
            if (sel_valid) begin
                rom_addr <= {sel_slot.main, sel_slot.chr};
                main_s1  <= sel_slot.main;
                xs_s1    <= sel_slot.x;
                xe_s1    <= end_of(sel_slot.x, sel_slot.main);
                ys_s1    <= sel_slot.y;
                ye_s1    <= end_of(sel_slot.y, sel_slot.main);
                color_s1 <= sel_slot.color;
            end
        end
    end

    // Stage 2: renderer-facing outputs, zeroed on a miss so it draws background.
    always_ff @(posedge clk) begin
        if (reset || !hit_s1) begin
            hit       <= 1'b0;
            main      <= 1'b0;
            x_start   <= '0;
            x_end     <= '0;
            y_start   <= '0;
            y_end     <= '0;
            rgb_color <= '0;
        end else begin
            hit       <= 1'b1;
            main      <= main_s1;
            x_start   <= xs_s1;
            x_end     <= xe_s1;
            y_start   <= ys_s1;
            y_end     <= ye_s1;
            rgb_color <= color_s1;
        end
    end

endmodule

// File: tb/tb_glyph_scheduler.sv
// tb/tb_glyph_scheduler.sv - self-checking bench for glyph_scheduler
module tb_glyph_scheduler;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [2:0]  waddr;
    logic [51:0] wdata;
    logic        frame_start, line_start;
    logic [9:0]  next_line, hcount, vcount;
    logic [6:0]  rom_addr;
    logic        main, hit, busy;
    logic [9:0]  x_start, x_end, y_start, y_end;
    logic [23:0] rgb_color;

    glyph_scheduler #(.N_SLOTS(N)) dut (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .frame_start(frame_start), .line_start(line_start), .next_line(next_line),
        .hcount(hcount), .vcount(vcount), .rom_addr(rom_addr), .main(main),
        .x_start(x_start), .x_end(x_end), .y_start(y_start), .y_end(y_end),
        .rgb_color(rgb_color), .hit(hit), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_on   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int sh_en[N], sh_main[N], sh_chr[N], sh_x[N], sh_y[N], sh_col[N];
    int ac_en[N], ac_main[N], ac_chr[N], ac_x[N], ac_y[N], ac_col[N];
    bit lm[N], work[N];
    bit scanning;
    int sk, sline;
    int e1_hit, e1_main, e1_xs, e1_xe, e1_ys, e1_ye, e1_col;
    int e2_hit, e2_main, e2_xs, e2_xe, e2_ys, e2_ye, e2_col;
    int e_rom;

    function automatic int endc(input int s, input int m);
        int e;
        e = s + (m != 0 ? 64 : 8);
        return (e > 1023) ? 1023 : e;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                sh_en[i] = 0; sh_main[i] = 0; sh_chr[i] = 0; sh_x[i] = 0; sh_y[i] = 0; sh_col[i] = 0;
                ac_en[i] = 0; ac_main[i] = 0; ac_chr[i] = 0; ac_x[i] = 0; ac_y[i] = 0; ac_col[i] = 0;
                lm[i] = 0; work[i] = 0;
            end
            scanning = 0; sk = 0; sline = 0;
            e1_hit = 0; e1_main = 0; e1_xs = 0; e1_xe = 0; e1_ys = 0; e1_ye = 0; e1_col = 0;
            e2_hit = 0; e2_main = 0; e2_xs = 0; e2_xe = 0; e2_ys = 0; e2_ye = 0; e2_col = 0;
            e_rom = 0;
        end else begin
            int f, h, v;
            e2_hit = e1_hit; e2_main = e1_main; e2_xs = e1_xs; e2_xe = e1_xe;
            e2_ys = e1_ys; e2_ye = e1_ye; e2_col = e1_col;
            h = int'(hcount); v = int'(vcount); f = -1;
            for (int i = 0; i < N; i++) begin
                if (f < 0 && lm[i] && ac_x[i] <= h && h < endc(ac_x[i], ac_main[i]) &&
                    ac_y[i] <= v && v < endc(ac_y[i], ac_main[i])) f = i;
            end
            if (f >= 0) begin
                e1_hit = 1; e1_main = ac_main[f]; e1_xs = ac_x[f]; e1_xe = endc(ac_x[f], ac_main[f]);
                e1_ys = ac_y[f]; e1_ye = endc(ac_y[f], ac_main[f]); e1_col = ac_col[f];
                e_rom = ac_main[f] * 64 + ac_chr[f];
            end else begin
                e1_hit = 0; e1_main = 0; e1_xs = 0; e1_xe = 0; e1_ys = 0; e1_ye = 0; e1_col = 0;
            end
            if (line_start) begin
                scanning = 1; sk = 0; sline = int'(next_line);
                for (int i = 0; i < N; i++) work[i] = 0;
            end else if (scanning) begin
                work[sk] = (ac_en[sk] != 0) && ac_y[sk] <= sline && sline < endc(ac_y[sk], ac_main[sk]);
                if (sk == N - 1) begin
                    for (int i = 0; i < N; i++) lm[i] = work[i];
                    scanning = 0;
                end else sk++;
            end
            if (frame_start) begin
                for (int i = 0; i < N; i++) begin
                    ac_en[i] = sh_en[i]; ac_main[i] = sh_main[i]; ac_chr[i] = sh_chr[i];
                    ac_x[i] = sh_x[i]; ac_y[i] = sh_y[i]; ac_col[i] = sh_col[i];
                end
            end
            if (we) begin
                sh_en[waddr]   = int'(wdata[51]);
                sh_main[waddr] = int'(wdata[50]);
                sh_chr[waddr]  = int'(wdata[49:44]);
                sh_x[waddr]    = int'(wdata[43:34]);
                sh_y[waddr]    = int'(wdata[33:24]);
                sh_col[waddr]  = int'(wdata[23:0]);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("busy", 32'(busy), 32'(scanning));
            chk("hit", 32'(hit), 32'(e2_hit));
            chk("main", 32'(main), 32'(e2_main));
            chk("x_start", 32'(x_start), 32'(e2_xs));
            chk("x_end", 32'(x_end), 32'(e2_xe));
            chk("y_start", 32'(y_start), 32'(e2_ys));
            chk("y_end", 32'(y_end), 32'(e2_ye));
            chk("rgb_color", 32'(rgb_color), 32'(e2_col));
            chk("rom_addr", 32'(rom_addr), 32'(e_rom));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [51:0] mk(input logic en, input logic mn, input logic [5:0] ch,
                                       input logic [9:0] x, input logic [9:0] y, input logic [23:0] c);
        return {en, mn, ch, x, y, c};
    endfunction

    task automatic write_slot(input logic [2:0] a, input logic [51:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick(1);
        we = 1'b0;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    task automatic scan_line(input logic [9:0] l);
        next_line = l; line_start = 1'b1;
        tick(1);
        line_start = 1'b0;
        chk("scan_busy_start", 32'(busy), 32'd1);
        tick(7);
        chk("scan_busy_last", 32'(busy), 32'd1);
        tick(1);
        chk("scan_busy_done", 32'(busy), 32'd0);
        tick(1);
    endtask

    task automatic pixel(input logic [9:0] h, input logic [9:0] v);
        hcount = h; vcount = v;
        tick(2);
    endtask

    logic [9:0] cur_line;

    initial begin
        reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        frame_start = 1'b0; line_start = 1'b0; next_line = '0;
        hcount = '0; vcount = '0; cur_line = '0;
        cmp_on = 1'b1;
        tick(3);
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rom", 32'(rom_addr), 32'd0);
        pixel(10'd103, 10'd42);
        chk("idle_hit", 32'(hit), 32'd0);

        // single small glyph
        write_slot(3'd2, mk(1'b1, 1'b0, 6'd5, 10'd100, 10'd40, 24'hFF0000));
        frame();
        scan_line(10'd42);
        pixel(10'd103, 10'd42);
        chk("t2_hit", 32'(hit), 32'd1);
        chk("t2_rom", 32'(rom_addr), 32'h05);
        chk("t2_xs", 32'(x_start), 32'd100);
        chk("t2_xe", 32'(x_end), 32'd108);
        chk("t2_ys", 32'(y_start), 32'd40);
        chk("t2_ye", 32'(y_end), 32'd48);
        chk("t2_rgb", 32'(rgb_color), 32'hFF0000);
        chk("t2_model_xe", 32'(e2_xe), 32'd108);

        // overlap: slot 0 wins
        write_slot(3'd0, mk(1'b1, 1'b1, 6'd7, 10'd96, 10'd0, 24'h00FF00));
        write_slot(3'd1, mk(1'b1, 1'b0, 6'd9, 10'd100, 10'd40, 24'h0000FF));
        frame();
        scan_line(10'd42);
        pixel(10'd100, 10'd42);
        chk("t3_main", 32'(main), 32'd1);
        chk("t3_xe", 32'(x_end), 32'd160);
        chk("t3_rom", 32'(rom_addr), 32'h47);
        chk("t3_rgb", 32'(rgb_color), 32'h00FF00);
        chk("t3_model_rom", 32'(e_rom), 32'h47);

        // shadow write invisible until commit
        write_slot(3'd3, mk(1'b1, 1'b0, 6'd3, 10'd300, 10'd42, 24'h123456));
        scan_line(10'd42);
        pixel(10'd302, 10'd42);
        chk("t4_hidden", 32'(hit), 32'd0);
        chk("t4_rom_hold", 32'(rom_addr), 32'h47);
        frame();
        scan_line(10'd42);
        pixel(10'd302, 10'd42);
        chk("t4_visible", 32'(hit), 32'd1);
        chk("t4_xs", 32'(x_start), 32'd300);
        chk("t4_rom", 32'(rom_addr), 32'h03);

        // right-edge saturation
        write_slot(3'd4, mk(1'b1, 1'b1, 6'd4, 10'd1020, 10'd200, 24'hABCDEF));
        frame();
        scan_line(10'd210);
        pixel(10'd1022, 10'd210);
        chk("t5_hit", 32'(hit), 32'd1);
        chk("t5_xe_sat", 32'(x_end), 32'h3FF);
        chk("t5_rom", 32'(rom_addr), 32'h44);
        chk("t5_model_xe", 32'(e2_xe), 32'h3FF);
        pixel(10'd1023, 10'd210);
        chk("t5_edge_miss", 32'(hit), 32'd0);
        pixel(10'd5, 10'd210);
        chk("t5_far_miss", 32'(hit), 32'd0);
        chk("t5_far_xe", 32'(x_end), 32'd0);

        // restart mid-scan
        next_line = 10'd42; line_start = 1'b1;
        tick(1);
        line_start = 1'b0;
        tick(3);
        next_line = 10'd210; line_start = 1'b1;
        tick(1);
        line_start = 1'b0;
        chk("t6_busy_1", 32'(busy), 32'd1);
        for (int k = 2; k <= 8; k++) begin
            tick(1);
            chk("t6_busy_run", 32'(busy), 32'd1);
        end
        tick(1);
        chk("t6_busy_end", 32'(busy), 32'd0);
        pixel(10'd302, 10'd42);
        chk("t6_old_line", 32'(hit), 32'd0);
        pixel(10'd1022, 10'd210);
        chk("t6_new_line", 32'(hit), 32'd1);

        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            we = ($urandom_range(3) == 0);
            waddr = 3'($urandom_range(7));
            wdata = mk(($urandom_range(3) != 0), ($urandom_range(2) == 0), 6'($urandom_range(63)),
                       ($urandom_range(7) == 0) ? 10'(960 + $urandom_range(63)) : 10'($urandom_range(255)),
                       10'($urandom_range(127)), 24'($urandom));
            frame_start = ($urandom_range(39) == 0);
            line_start  = ($urandom_range(11) == 0);
            next_line   = 10'($urandom_range(159));
            if (line_start) cur_line = next_line;
            hcount = ($urandom_range(7) == 0) ? 10'(960 + $urandom_range(63)) : 10'($urandom_range(255));
            vcount = ($urandom_range(3) == 0) ? 10'($urandom_range(159)) : cur_line;
            tick(1);
        end
        we = 1'b0; frame_start = 1'b0; line_start = 1'b0;
        tick(12);
        cmp_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/glyph_scheduler.md
Name: glyph_scheduler

Overview:
- Sequences the per-pixel glyph renderer: holds a table of N on-screen text slots (character, position, size, colour).
- Each line, it scans the table during horizontal blanking to build an active-slot mask.
- Per pixel, it selects the highest-priority slot covering (hcount, vcount), issues the font-ROM address, and drives that glyph's window and colour to the renderer.
- CPU writes go to a shadow table committed at frame start, so text never tears mid-frame.

Parameters:
- N_SLOTS, 8, number of text slots; slot 0 has the highest priority.
- SMALL_SZ, 8, edge length in pixels of a small glyph (main=0).
- BIG_SZ, 64, edge length in pixels of a large glyph (main=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- we  in  1  shadow-table write strobe.
- waddr  in  $clog2(N_SLOTS)  slot index to write.
- wdata  in  52  {en[51], main[50], char[49:44], x[43:34], y[33:24], color[23:0]}.
- frame_start  in  1  one-cycle pulse at top of frame; commits shadow table to active table.
- line_start  in  1  one-cycle pulse at start of hblank; starts the slot scan.
- next_line  in  10  vcount of the upcoming line, sampled on line_start.
- hcount  in  10  current pixel column.
- vcount  in  10  current pixel row.
- rom_addr  out  7  {main, char} to the font ROM; ROM data is valid 1 clk later.
- main  out  1  large-glyph select to the renderer.
- x_start, x_end, y_start, y_end  out  10 each  window of the selected glyph.
- rgb_color  out  24  colour of the selected glyph.
- hit  out  1  a slot covers the pixel.
- busy  out  1  scan in progress.

Behaviour:
- Reset: shadow and active tables cleared (all en=0); line mask=0; FSM=IDLE.
  - All outputs 0: rom_addr, main, windows, rgb_color, hit, busy.
- Writes: on we, shadow[waddr] <= wdata. Writes never touch the active table directly.
- Commit: on frame_start, active <= shadow (all slots, 1 cycle).
  - A write in the same cycle as frame_start lands in shadow only; it appears in the following frame.
- Size rule: sz = main ? BIG_SZ : SMALL_SZ.
  - End coordinates are computed in 11 bits, then saturated to 10'h3FF.
  - Coverage test: start <= coord < end.
- Scan FSM has two states, IDLE and SCAN:
  - IDLE to SCAN on line_start. Latch next_line, clear the working mask, idx=0, busy=1.
  - SCAN: one slot per clk. mask_work[idx] = en && (y <= next_line < y_end(y)). idx++.
  - After slot N_SLOTS-1: line_mask <= mask_work, go to IDLE, busy=0. Scan takes exactly N_SLOTS clks.
  - line_start during SCAN restarts the scan from idx 0 with the new next_line; line_mask is unchanged until a scan completes.
  - frame_start during SCAN: the commit happens, and the scan continues reading the newly committed active table.
- Per-pixel path, pipelined with 2 clk total latency:
  - Stage 1 (registered): sel = lowest index i with line_mask[i] && x_i <= hcount < x_end(x_i) && y_i <= vcount < y_end(y_i). The vcount re-check guards against a stale mask.
  - Stage 1 also registers rom_addr <= {main_sel, char_sel} and carries hit_s1.
  - Stage 2 (registered): main, x_start, x_end, y_start, y_end, rgb_color, hit <= stage-1 values. These align with ROM data.
  - Top level delays hcount/vcount/bright by 2 clks to the renderer.
- No hit: rom_addr holds its previous value. Stage 2 drives main=0, all windows 0, rgb_color=0, hit=0; the renderer then outputs background.
- Overlaps: the lower slot index always wins. Pixels of a higher-index glyph under a lower-index glyph box are not drawn, even where the lower glyph's bitmap bit is 0.

Decomposition:
- Shared package glyph_sched_pkg holds:
  - wdata field offsets and widths;
  - the slot struct typedef {en, main, char, x, y, color};
  - SMALL_SZ/BIG_SZ constants;
  - the saturating end-coordinate function.
- One sub-module, glyph_prio_enc: combinational N_SLOTS-way lowest-index priority encoder, producing sel index and valid.

Test Plan:
- Reset then idle, no writes -> all outputs 0, busy=0, hit=0 for any hcount/vcount.
- Write slot 2 {en=1, main=0, char=5, x=100, y=40, color=FF0000}, frame_start, line_start with next_line=42, wait 8 clks, drive hcount=103/vcount=42 -> 2 clks later hit=1, rom_addr=0x05, x_start=100, x_end=108, y_start=40, y_end=48, rgb_color=FF0000.
- Slot 0 big at (96,0), slot 1 small at (100,40), both en; pixel (100,42) -> slot 0 wins: main=1, x_end=160, rom_addr={1,char0}.
- Write slot 3 during a frame without frame_start, then scan and draw -> slot 3 not visible; after the next frame_start it is visible.
- Slot with x=1020, main=1 -> x_end saturates to 1023. Pixel (1022, y) hits; pixel (5, y) does not.
- line_start issued again at scan cycle 4 with a different next_line -> busy stays 1 for 8 further clks; the final mask reflects only the second next_line.
